// File: rtl/movegen_sequencer.sv
// Move-generation control stage: walks the side-to-move's pieces in ascending square order,
// strobes each origin into the array and streams the resulting (from,to) pairs to a consumer.
module movegen_sequencer #(
  parameter int NSQ   = 64,
  parameter int CNT_W = 8,
  localparam int IDX_W = $clog2(NSQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             wtp_in,
  input  logic [NSQ-1:0]   play_mask,
  input  logic [NSQ-1:0]   target_square,
  output logic [NSQ-1:0]   emit_move,
  output logic             wtp,
  output logic             busy,
  output logic             done,
  output logic             move_valid,
  input  logic             move_ready,
  output logic [IDX_W-1:0] move_from,
  output logic [IDX_W-1:0] move_to,
  output logic [CNT_W-1:0] move_count
);

  typedef enum logic [2:0] {IDLE, SCAN, EMIT, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic [NSQ-1:0]   pmask, pmask_n;
  logic [NSQ-1:0]   tmask, tmask_n;
  logic [IDX_W-1:0] cur, cur_n;
  logic             wtp_n;
  logic [CNT_W-1:0] cnt_n;
  logic [IDX_W-1:0] last_from, last_from_n;
  logic [IDX_W-1:0] last_to, last_to_n;
  logic [IDX_W-1:0] lo_p, lo_t;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NSQ-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NSQ - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [NSQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NSQ-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  assign lo_p = lowest_set(pmask);
  assign lo_t = lowest_set(tmask);

  always_comb begin
    state_n     = state;
    pmask_n     = pmask;
    tmask_n     = tmask;
    cur_n       = cur;
    wtp_n       = wtp;
    cnt_n       = move_count;
    last_from_n = last_from;
    last_to_n   = last_to;
    case (state)
      IDLE: begin
        if (start) begin
          pmask_n = play_mask;
          wtp_n   = wtp_in;
          cnt_n   = '0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (pmask == '0) begin
          state_n = DONE;
        end else begin
          cur_n   = lo_p;
          pmask_n = pmask & ~onehot(lo_p);
          state_n = EMIT;
        end
      end
      EMIT: begin
        // A piece never moves onto its own square, whatever the array reports.
        tmask_n = target_square & ~onehot(cur);
        state_n = (tmask_n != '0) ? DRAIN : SCAN;
      end
      DRAIN: begin
        if (move_ready) begin
          tmask_n     = tmask & ~onehot(lo_t);
          cnt_n       = sat_inc(move_count);
          last_from_n = cur;
          last_to_n   = lo_t;
          if (tmask_n == '0) state_n = SCAN;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pmask      <= '0;
      tmask      <= '0;
      cur        <= '0;
      wtp        <= 1'b0;
      move_count <= '0;
      last_from  <= '0;
      last_to    <= '0;
    end else begin
      state      <= state_n;
      pmask      <= pmask_n;
      tmask      <= tmask_n;
      cur        <= cur_n;
      wtp        <= wtp_n;
      move_count <= cnt_n;
      last_from  <= last_from_n;
      last_to    <= last_to_n;
    end
  end

  // Outside DRAIN the stream fields hold the last accepted move rather than tracking cur.
  assign emit_move  = (state == EMIT) ? onehot(cur) : '0;
  assign busy       = (state == SCAN) || (state == EMIT) || (state == DRAIN);
  assign done       = (state == DONE);
  assign move_valid = (state == DRAIN);
  assign move_from  = (state == DRAIN) ? cur  : last_from;
  assign move_to    = (state == DRAIN) ? lo_t : last_to;

endmodule

// File: tb/tb_movegen_sequencer.sv
// Scoreboard bench for movegen_sequencer: directed positions, a table-driven model of the
// move array, and a monitor that checks every strobe and every presented move in order.
module tb_movegen_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        wtp_in;
  logic [63:0] play_mask;
  logic [63:0] target_square;
  logic [63:0] emit_move;
  logic        wtp, busy, done, move_valid, move_ready;
  logic [5:0]  move_from, move_to;
  logic [7:0]  move_count;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int rmode = 0;

  logic [63:0] tgt [64];
  logic [11:0] exp_moves [$];
  int          exp_emit [$];

  movegen_sequencer #(.NSQ(64), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wtp_in(wtp_in), .play_mask(play_mask),
    .target_square(target_square), .emit_move(emit_move), .wtp(wtp), .busy(busy),
    .done(done), .move_valid(move_valid), .move_ready(move_ready), .move_from(move_from),
    .move_to(move_to), .move_count(move_count)
  );

  always #5 clk = ~clk;

  // Array model: answers the strobed origin, otherwise presents unrelated garbage.
  always_comb begin
    target_square = 64'hA5A5_5A5A_F0F0_0F0F;
    for (int i = 0; i < 64; i++) begin
      if (emit_move[i]) target_square = tgt[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%h expected=none", nm, act);
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst_n) begin
      if (emit_move != 64'd0) begin
        if (exp_emit.size() == 0) unexpected("emit_move", emit_move);
        else begin
          chk("emit_move", emit_move, 64'd1 << exp_emit[0]);
          void'(exp_emit.pop_front());
        end
      end
      if (move_valid) begin
        if (exp_moves.size() == 0) unexpected("move", {52'd0, move_from, move_to});
        else begin
          chk("move", {52'd0, move_from, move_to}, {52'd0, exp_moves[0]});
          if (move_ready) void'(exp_moves.pop_front());
        end
      end
    end
  end

  initial begin
    move_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       move_ready = 1'b1;
        1:       move_ready = ~move_ready;
        default: move_ready = 1'b0;
      endcase
    end
  end

  task automatic mv(input int f, input int t);
    logic [5:0] f6, t6;
    f6 = 6'(f);
    t6 = 6'(t);
    exp_moves.push_back({f6, t6});
  endtask

  task automatic clear_tgt();
    for (int i = 0; i < 64; i++) tgt[i] = 64'd0;
  endtask

  task automatic run(input logic [63:0] mask, input logic w, output int lat, output logic busy1);
    @(posedge clk);
    #1;
    start = 1'b1;
    play_mask = mask;
    wtp_in = w;
    @(posedge clk);
    #1;
    start = 1'b0;
    play_mask = 64'hFFFF_0000_FFFF_0000;
    wtp_in = ~w;
    lat = 0;
    busy1 = 1'b0;
    while (lat < 500) begin
      @(negedge clk);
      lat++;
      if (lat == 1) busy1 = busy;
      if (done) break;
    end
    if (!done) unexpected("done_timeout", 64'(lat));
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    chk("moves_left", 64'(exp_moves.size()), 64'd0);
    chk("emits_left", 64'(exp_emit.size()), 64'd0);
  endtask

  int   lat;
  logic b1;
  int   dn0;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    wtp_in = 1'b0;
    play_mask = 64'd0;
    clear_tgt();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {emit_move[15:0], 7'd0, wtp, busy, done, move_valid, move_from, move_to, move_count},
        64'd0);
    #2 rst_n = 1'b1;

    // Empty mask: SCAN then DONE
    run(64'd0, 1'b1, lat, b1);
    chk("t1_latency", 64'(lat), 64'd2);
    chk("t1_busy", {63'd0, b1}, 64'd1);
    chk("t1_count", {56'd0, move_count}, 64'd0);

    // Single pawn e2 -> e3, e4
    clear_tgt();
    tgt[12] = (64'd1 << 20) | (64'd1 << 28);
    exp_emit.push_back(12);
    mv(12, 20); mv(12, 28);
    run(64'd1 << 12, 1'b1, lat, b1);
    chk("t2_latency", 64'(lat), 64'd6);
    chk("t2_count", {56'd0, move_count}, 64'd2);
    chk("t2_wtp", {63'd0, wtp}, 64'd1);

    // Two knights with a toggling consumer
    clear_tgt();
    tgt[1] = (64'd1 << 16) | (64'd1 << 18);
    tgt[6] = (64'd1 << 21) | (64'd1 << 23);
    exp_emit.push_back(1); exp_emit.push_back(6);
    mv(1, 16); mv(1, 18); mv(6, 21); mv(6, 23);
    rmode = 1;
    run((64'd1 << 1) | (64'd1 << 6), 1'b0, lat, b1);
    rmode = 0;
    chk("t3_count", {56'd0, move_count}, 64'd4);
    chk("t3_wtp", {63'd0, wtp}, 64'd0);

    // Own-square-only, mixed, and empty target sets
    clear_tgt();
    tgt[3] = 64'd1 << 3;
    tgt[9] = (64'd1 << 9) | (64'd1 << 17);
    tgt[40] = 64'd0;
    exp_emit.push_back(3); exp_emit.push_back(9); exp_emit.push_back(40);
    mv(9, 17);
    run((64'd1 << 3) | (64'd1 << 9) | (64'd1 << 40), 1'b1, lat, b1);
    chk("t4_latency", 64'(lat), 64'd9);
    chk("t4_count", {56'd0, move_count}, 64'd1);

    // Second start while busy is ignored
    clear_tgt();
    tgt[12] = (64'd1 << 20) | (64'd1 << 28);
    tgt[0] = 64'd1 << 8;
    exp_emit.push_back(12);
    mv(12, 20); mv(12, 28);
    fork
      run(64'd1 << 12, 1'b1, lat, b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        play_mask = 64'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join
    chk("t5_latency", 64'(lat), 64'd6);
    chk("t5_count", {56'd0, move_count}, 64'd2);
    repeat (4) @(negedge clk);
    chk("t5_idle_busy", {63'd0, busy}, 64'd0);

    // Reset during a stalled DRAIN
    rmode = 2;
    exp_emit.push_back(12);
    mv(12, 20);
    @(posedge clk);
    #1;
    start = 1'b1;
    play_mask = 64'd1 << 12;
    wtp_in = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (lat < 20 && !move_valid) begin
      @(negedge clk);
      lat++;
    end
    chk("t6_valid_seen", {63'd0, move_valid}, 64'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_rst", {emit_move[15:0], 7'd0, wtp, busy, done, move_valid, move_from, move_to, move_count},
        64'd0);
    exp_moves.delete();
    exp_emit.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    rmode = 0;
    dn0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("t6_no_done", 64'(done_cnt), 64'(dn0));
    exp_emit.push_back(12);
    mv(12, 20); mv(12, 28);
    run(64'd1 << 12, 1'b1, lat, b1);
    chk("t6_restart_lat", 64'(lat), 64'd6);
    chk("t6_restart_cnt", {56'd0, move_count}, 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
